seg_scan_ctrl: RTL

Parametrised multiplexed 7-segment scan controller. It supersedes the fixed 8-digit scanner with the following additions:
- configurable digit count and scan rate
- decimal points
- per-digit blanking and leading-zero suppression
- anti-ghosting dead time
- frame-synchronous data latching, so a digit never shows half-updated data

It sits between the display-data producers and the hc595 shift-out block, which serialises sel/seg/dp.

---
 rtl/seg_pkg.sv | 21 ++
 rtl/seg7_decoder.sv | 18 +
 rtl/seg_scan_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan controller: FSM state codes,
// the active-low hex glyph table and the decode helper.
package seg_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

    localparam logic [6:0] DARK_SEG = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} glyphs, entry 15 (F) first down to entry 0
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex-to-7-segment decoder with forced blanking and
// selectable output polarity.
module seg7_decoder
    import seg_pkg::*;
#(
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    logic [6:0] activeLow;

    assign activeLow = blank_i ? DARK_SEG : seg_decode(nibble_i);
    assign seg_o     = (SEG_ACTIVE_LOW != 0) ? activeLow : ~activeLow;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: per-digit dwell with leading dead
// time, frame-synchronous input latching and leading-zero suppression.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int CLK_FREQ_HZ    = 50_000_000,
    parameter int SCAN_HZ        = 1000,
    parameter int BLANK_CYCLES   = 16,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int SEL_ACTIVE_LOW = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic [4*NUM_DIGITS-1:0] disp_data_i,
    input  logic [NUM_DIGITS-1:0]   dp_in_i,
    input  logic [NUM_DIGITS-1:0]   blank_mask_i,
    input  logic                    lz_suppress_i,
    output logic [NUM_DIGITS-1:0]   sel_o,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic                    frame_done_o
);

    localparam int DIGIT_CYCLES = CLK_FREQ_HZ / SCAN_HZ;
    localparam int CNT_W = ($clog2(DIGIT_CYCLES) > 0) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int IDX_W = ($clog2(NUM_DIGITS) > 0) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    localparam logic [NUM_DIGITS-1:0] SEL_OFF = (SEL_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? DARK_SEG : 7'h00;
    localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);

    logic [1:0]              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    latch;
    logic                    frameEnd;

    logic [4*NUM_DIGITS-1:0] dispData_q;
    logic [NUM_DIGITS-1:0]   dpLatch_q;
    logic [NUM_DIGITS-1:0]   blankMask_q;
    logic [NUM_DIGITS-1:0]   lzBlank_q, lzBlank_d;
    logic                    allZero;

    logic [3:0]              nibble;
    logic                    digitDark;
    logic                    digitDp;
    logic [NUM_DIGITS-1:0]   selOneHot;
    logic                    showNext;

    logic [NUM_DIGITS-1:0]   selOut_q, selOut_d;
    logic [6:0]              segOut_q, segOut_d;
    logic                    dpOut_q, dpOut_d;
    logic                    frameDone_q;

    // Dropping en always wins, including over a frame end on the same cycle
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        latch    = 1'b0;
        frameEnd = 1'b0;
        if (!en_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = '0;
                    latch   = 1'b1;
                end
                ST_BLANK: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_BLANK;
                        if (idx_q == IDX_LAST) begin
                            idx_d    = '0;
                            frameEnd = 1'b1;
                            latch    = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // A digit is LZ-dark only if it and every more-significant nibble are zero
    always_comb begin
        lzBlank_d = '0;
        allZero   = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            allZero      = allZero && (disp_data_i[4*i +: 4] == 4'h0);
            lzBlank_d[i] = lz_suppress_i && (i > 0) && allZero;
        end
    end

    always_comb begin
        nibble    = 4'h0;
        digitDark = 1'b0;
        digitDp   = 1'b0;
        selOneHot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                nibble       = dispData_q[4*i +: 4];
                digitDark    = blankMask_q[i] | lzBlank_q[i];
                digitDp      = dpLatch_q[i];
                selOneHot[i] = 1'b1;
            end
        end
    end

    // Outputs are precomputed from next-state so they change on the same edge
    assign showNext = (state_d == ST_SHOW);
    assign selOut_d = showNext ? ((SEL_ACTIVE_LOW != 0) ? ~selOneHot : selOneHot) : SEL_OFF;
    assign dpOut_d  = DP_OFF ? ~(showNext && digitDp) : (showNext && digitDp);

    seg7_decoder #(
        .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
    ) u_decoder (
        .nibble_i(nibble),
        .blank_i (!showNext || digitDark),
        .seg_o   (segOut_d)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            dispData_q  <= '0;
            dpLatch_q   <= '0;
            blankMask_q <= '0;
            lzBlank_q   <= '0;
            selOut_q    <= SEL_OFF;
            segOut_q    <= SEG_OFF;
            dpOut_q     <= DP_OFF;
            frameDone_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            selOut_q    <= selOut_d;
            segOut_q    <= segOut_d;
            dpOut_q     <= dpOut_d;
            frameDone_q <= frameEnd;
            if (latch) begin
                dispData_q  <= disp_data_i;
                dpLatch_q   <= dp_in_i;
                blankMask_q <= blank_mask_i;
                lzBlank_q   <= lzBlank_d;
            end
        end
    end

    assign sel_o        = selOut_q;
    assign seg_o        = segOut_q;
    assign dp_o         = dpOut_q;
    assign frame_done_o = frameDone_q;

endmodule
